// File: rtl/hdu.sv
// ---------------------------------------------------------------------------
// hdu -- hazard detection and pipeline sequencing unit for the 5-stage core
//
// Collects the hazard requests raised by the pipeline stages and turns them
// into the per-stage stall/flush controls that gate the pipeline registers.
// After a trap that lands on a busy memory access it runs a DRAIN phase,
// guarded by a watchdog, until the killed access has finished. Two
// saturating performance counters track stalled cycles and redirects.
//
// Parameters:
//   CNT_W          width of the performance counters
//   DRAIN_TIMEOUT  maximum number of DRAIN cycles before a forced exit (>= 1)
//
// Ports:
//   clk             core clock
//   rst             synchronous, active-low reset
//   hdu_load_stall  load-use dependency detected in ID
//   ex_branch_take  branch/jal/jalr in EX redirects the PC
//   if_busy         instruction fetch not complete this cycle
//   mem_busy        data memory access in MEM not complete this cycle
//   trap_take       exception/interrupt/mret committed; PC redirects now
//   pc_stall        hold the PC register
//   if_stall        hold the if2id register
//   id_stall        hold the id2ex register
//   ex_stall        hold the ex2mem register
//   mem_stall       hold the mem2wb register
//   if_flush        zero if2id ctrl (bubble)
//   id_flush        zero id2ex ctrl/exc
//   ex_flush        zero ex2mem ctrl
//   mem_flush       zero mem2wb ctrl
//   drain_timeout   sticky flag, the DRAIN watchdog expired
//   stall_cycles    count of cycles with pc_stall=1 (saturating)
//   redirect_count  count of branch/trap redirects (saturating)
// ---------------------------------------------------------------------------
module hdu #(
   parameter int CNT_W         = 32,
   parameter int DRAIN_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hdu_load_stall,
   input  logic             ex_branch_take,
   input  logic             if_busy,
   input  logic             mem_busy,
   input  logic             trap_take,
   output logic             pc_stall,
   output logic             if_stall,
   output logic             id_stall,
   output logic             ex_stall,
   output logic             mem_stall,
   output logic             if_flush,
   output logic             id_flush,
   output logic             ex_flush,
   output logic             mem_flush,
   output logic             drain_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_count
);

   // Drain counter is wide enough to hold DRAIN_TIMEOUT itself.
   localparam int DCNT_W = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_TIMEOUT - 1);

   typedef enum logic {
      RUN,
      DRAIN
   } state_t;

   state_t            state;
   logic [DCNT_W-1:0] drain_cnt;
   logic              branch_redirect;

   // Stall/flush decode. Purely combinational so a hazard takes effect in
   // the same cycle it is raised. In RUN the requests are resolved by fixed
   // priority: trap, memory wait, branch, load-use, fetch wait. A branch
   // seen while MEM is busy is not acted on yet; EX is frozen, so the
   // request stays asserted and wins once the memory wait clears. DRAIN
   // freezes the front end and MEM while the killed access completes.
   always_comb begin
      pc_stall        = 1'b0;
      if_stall        = 1'b0;
      id_stall        = 1'b0;
      ex_stall        = 1'b0;
      mem_stall       = 1'b0;
      if_flush        = 1'b0;
      id_flush        = 1'b0;
      ex_flush        = 1'b0;
      mem_flush       = 1'b0;
      branch_redirect = 1'b0;
      if (rst) begin
         unique case (state)
            RUN: begin
               if (trap_take) begin
                  if_flush  = 1'b1;
                  id_flush  = 1'b1;
                  ex_flush  = 1'b1;
                  mem_flush = 1'b1;
               end else if (mem_busy) begin
                  pc_stall  = 1'b1;
                  if_stall  = 1'b1;
                  id_stall  = 1'b1;
                  ex_stall  = 1'b1;
                  mem_stall = 1'b1;
               end else if (ex_branch_take) begin
                  if_flush        = 1'b1;
                  id_flush        = 1'b1;
                  branch_redirect = 1'b1;
               end else if (hdu_load_stall) begin
                  pc_stall = 1'b1;
                  if_stall = 1'b1;
                  id_flush = 1'b1;
               end else if (if_busy) begin
                  pc_stall = 1'b1;
                  if_flush = 1'b1;
               end
            end
            DRAIN: begin
               pc_stall  = 1'b1;
               mem_stall = 1'b1;
               if_flush  = 1'b1;
               id_flush  = 1'b1;
               ex_flush  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Sequencer state, drain watchdog and performance counters. A trap taken
   // while MEM is busy cannot cancel the in-flight access, so the unit waits
   // in DRAIN until mem_busy drops. The watchdog bounds that wait; once it
   // fires the sticky flag stays set until reset. A trap during DRAIN
   // restarts the wait from zero. Both counters stop at all-ones instead of
   // wrapping so long runs never read back as small numbers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= RUN;
         drain_cnt      <= '0;
         drain_timeout  <= 1'b0;
         stall_cycles   <= '0;
         redirect_count <= '0;
      end else begin
         if (pc_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if ((trap_take || branch_redirect) && (redirect_count != '1)) begin
            redirect_count <= redirect_count + CNT_W'(1);
         end
         unique case (state)
            RUN: begin
               if (trap_take) begin
                  drain_cnt <= '0;
                  state     <= mem_busy ? DRAIN : RUN;
               end
            end
            DRAIN: begin
               if (trap_take) begin
                  drain_cnt <= '0;
                  state     <= DRAIN;
               end else if (!mem_busy) begin
                  drain_cnt <= '0;
                  state     <= RUN;
               end else if (drain_cnt == DRAIN_LAST) begin
                  drain_cnt     <= '0;
                  drain_timeout <= 1'b1;
                  state         <= RUN;
               end else begin
                  drain_cnt <= drain_cnt + DCNT_W'(1);
               end
            end
            default: begin
               state     <= RUN;
               drain_cnt <= '0;
            end
         endcase
      end
   end

endmodule
